fpga_apb_ahb_bridge: RTL and testbench
======================================

# fpga_apb_ahb_bridge

Registered APB3 (slave side) to AHB-Lite (master side) bridge for the V2M-MPS2 FPGA configuration path. It sits directly downstream of the SPI-to-APB3 converter and upstream of the FPGA system AHB matrix. Each APB transfer becomes exactly one AHB SINGLE transfer with a proper address/data phase split, wait-state tracking and two-cycle ERROR handling, and HRESPM is reported back on PSLVERR.

## Interface
- ADDR_WIDTH, 32: width of PADDR/HADDRM.
- HPROT_VALUE, 4'hF: constant driven on HPROTM.

- HCLK  in  1  system clock; all state on rising edge.
- nPOR  in  1  asynchronous active-low reset.
- PSEL, PENABLE, PWRITE  in  1 each  APB3 control.
- PADDR  in  ADDR_WIDTH  APB address.
- PWDATA  in  32  APB write data.
- PSTRB  in  4  APB write strobes.
- PRDATA  out  32  registered read data.
- PREADY  out  1  APB ready.
- PSLVERR  out  1  APB error, valid only with PREADY.
- HSELM, HWRITEM, HMASTLOCKM, EXREQM  out  1 each  AHB control.
- HADDRM  out  ADDR_WIDTH  AHB address.
- HTRANSM  out  2  AHB transfer type.
- HSIZEM, HBURSTM  out  3 each  AHB size and burst.
- HMASTERM, HPROTM  out  4 each  master ID and protection.
- MEMATTRM  out  2  memory attributes.
- HWDATAM  out  32  AHB write data.
- HREADYM, HRESPM, EXRESPM  in  1 each  AHB response (EXRESPM ignored).
- HRDATAM  in  32  AHB read data.

## Operation
- FSM states: IDLE, ADDR, DATA, ERR, RESP.
- IDLE: when PSEL=1, register PADDR, PWRITE, PWDATA and the decoded size, then go to ADDR. If the strobe decode is invalid (macro on), go directly to RESP with the error flag set.
- ADDR: HSELM=1, HTRANSM=NONSEQ (2'b10). On HREADYM=1 go to DATA. Otherwise hold all address-phase signals stable.
- DATA: HTRANSM=IDLE, HSELM=0, HWDATAM holds the registered data.
  - HREADYM=1, HRESPM=0: capture HRDATAM into PRDATA on reads (PRDATA is unchanged on writes), clear the error flag, go to RESP.
  - HREADYM=0, HRESPM=1: go to ERR.
  - HREADYM=1, HRESPM=1 (protocol violation): treat as error and go to RESP.
- ERR: wait for HREADYM=1, set the error flag, go to RESP.
- RESP: PREADY=1, PSLVERR=error flag; go to IDLE next cycle.
- PREADY=0 in all other states.
- Constant outputs: HMASTERM=0, HMASTLOCKM=0, HBURSTM=SINGLE, HPROTM=HPROT_VALUE, MEMATTRM=0, EXREQM=0.
- At most one outstanding transfer. No bursts.
- Reset values: state IDLE, HSELM=0, HTRANSM=IDLE, HADDRM=0, HWRITEM=0, HSIZEM=3'b010, HWDATAM=0, PRDATA=0, PREADY=0, PSLVERR=0.
- Reset asserted mid-transfer abandons it immediately; AHB outputs return to their reset values asynchronously.

## Timing
- Zero-wait path, with T0 = first cycle PSEL=1: T1 ADDR, T2 DATA, T3 RESP (PREADY=1). An APB access completes in 4 HCLK cycles.
- Each AHB wait state in the address phase or data phase adds exactly 1 cycle.
- AHB ERROR response: 1 extra cycle (ERR state).
- Back-to-back APB transfers: the new setup cycle is the cycle after RESP. No dead cycle is added beyond the APB setup phase.
- PRDATA and PSLVERR are stable throughout RESP.

## Configuration
- FPGA_APB_AHB_STRB_EN defined: writes decode PSTRB into HSIZEM and HADDRM[1:0].
  - 1111 → word, lsbs 00.
  - 0011 → half, lsbs 00.
  - 1100 → half, lsbs 10.
  - single bit n → byte, lsbs n.
  - Any other non-zero or zero write strobe → no AHB transfer; PSLVERR=1 after 1 cycle (IDLE→RESP).
  - Reads are always word, lsbs 00.
- Undefined: PSTRB is ignored, every transfer is word, HADDRM[1:0] is forced to 00.

## Structure
- Package fpga_apb_ahb_pkg holds:
  - the state encoding;
  - HTRANS constants (IDLE, NONSEQ);
  - HSIZE constants (BYTE, HALF, WORD);
  - HBURST SINGLE.
- Sub-module fpga_apb_ahb_strb_dec (combinational): maps PSTRB and PWRITE to size, address lsbs and a valid flag. It is instantiated only under FPGA_APB_AHB_STRB_EN.

## Test plan
- Zero-wait write, PADDR=0x2000_0010, PWDATA=0xDEADBEEF → one NONSEQ with HADDRM=0x2000_0010, HWDATAM=0xDEADBEEF in the following cycle, PREADY at T3, PSLVERR=0.
- Read with 2 data-phase wait states, HRDATAM=0x1234_5678 → PREADY at T5, PRDATA=0x1234_5678.
- AHB ERROR on write (HRESPM=1 for two cycles) → PSLVERR=1 with PREADY, exactly one NONSEQ issued.
- Macro on: write PSTRB=1100 → HSIZEM=HALF, HADDRM[1:0]=10. Write PSTRB=0101 → no HTRANSM=NONSEQ, PSLVERR=1 after 1 cycle.
- nPOR asserted while in DATA → HTRANSM=IDLE and PREADY=0 immediately. After release, a new write completes normally.
- Two back-to-back reads → two NONSEQs, each PRDATA correct, no extra idle cycles between APB transfers.

Source files
------------

// File: rtl/fpga_apb_ahb_pkg.sv
// Shared types and AHB-Lite encodings for the APB3 -> AHB-Lite configuration bridge.
package fpga_apb_ahb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR  = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Result of turning an APB strobe pattern into an AHB size/alignment.
    typedef struct packed {
        logic [2:0] size;
        logic [1:0] lsbs;
        logic       valid;
    } strb_dec_t;

endpackage

// File: rtl/fpga_apb_ahb_strb_dec.sv
// Strobe-to-size decoder, only built when FPGA_APB_AHB_STRB_EN is defined.
// Reads are always full words; writes must use an aligned byte, half or word lane set.
`ifdef FPGA_APB_AHB_STRB_EN
module fpga_apb_ahb_strb_dec
    import fpga_apb_ahb_pkg::*;
(
    input  logic       pwrite_i,
    input  logic [3:0] pstrb_i,
    output strb_dec_t  dec_o
);

    // Map the strobe pattern onto HSIZE and the low address bits.
    always_comb begin
        dec_o = '{size: HSIZE_WORD, lsbs: 2'b00, valid: 1'b1};
        if (pwrite_i) begin
            case (pstrb_i)
                4'b1111: dec_o = '{size: HSIZE_WORD, lsbs: 2'b00, valid: 1'b1};
                4'b0011: dec_o = '{size: HSIZE_HALF, lsbs: 2'b00, valid: 1'b1};
                4'b1100: dec_o = '{size: HSIZE_HALF, lsbs: 2'b10, valid: 1'b1};
                4'b0001: dec_o = '{size: HSIZE_BYTE, lsbs: 2'b00, valid: 1'b1};
                4'b0010: dec_o = '{size: HSIZE_BYTE, lsbs: 2'b01, valid: 1'b1};
                4'b0100: dec_o = '{size: HSIZE_BYTE, lsbs: 2'b10, valid: 1'b1};
                4'b1000: dec_o = '{size: HSIZE_BYTE, lsbs: 2'b11, valid: 1'b1};
                default: dec_o = '{size: HSIZE_WORD, lsbs: 2'b00, valid: 1'b0};
            endcase
        end else begin
            dec_o = '{size: HSIZE_WORD, lsbs: 2'b00, valid: 1'b1};
        end
    end

endmodule
`endif

// File: rtl/fpga_apb_ahb_bridge.sv
// Registered APB3 slave to AHB-Lite master bridge: one APB access becomes one AHB SINGLE.
// Define FPGA_APB_AHB_STRB_EN to map write strobes onto HSIZEM/HADDRM[1:0].
module fpga_apb_ahb_bridge
    import fpga_apb_ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter logic [3:0]  HPROT_VALUE = 4'hF
) (
    input  logic                  HCLK,
    input  logic                  nPOR,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]           PWDATA,
    input  logic [3:0]            PSTRB,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  HSELM,
    output logic                  HWRITEM,
    output logic                  HMASTLOCKM,
    output logic                  EXREQM,
    output logic [ADDR_WIDTH-1:0] HADDRM,
    output logic [1:0]            HTRANSM,
    output logic [2:0]            HSIZEM,
    output logic [2:0]            HBURSTM,
    output logic [3:0]            HMASTERM,
    output logic [3:0]            HPROTM,
    output logic [1:0]            MEMATTRM,
    output logic [31:0]           HWDATAM,
    input  logic                  HREADYM,
    input  logic                  HRESPM,
    input  logic                  EXRESPM,
    input  logic [31:0]           HRDATAM
);

    state_e                  state_q;
    logic                    hsel_q;
    logic [1:0]              htrans_q;
    logic [ADDR_WIDTH-1:0]   haddr_q;
    logic                    hwrite_q;
    logic [2:0]              hsize_q;
    logic [31:0]             hwdata_q;
    logic [31:0]             prdata_q;
    logic                    pready_q;
    logic                    pslverr_q;

    strb_dec_t               dec_s;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic                    unused_s;

`ifdef FPGA_APB_AHB_STRB_EN
    fpga_apb_ahb_strb_dec u_strb_dec (
        .pwrite_i (PWRITE),
        .pstrb_i  (PSTRB),
        .dec_o    (dec_s)
    );
    assign unused_s = ^{PENABLE, EXRESPM, PADDR[1:0]};
`else
    assign dec_s    = '{size: HSIZE_WORD, lsbs: 2'b00, valid: 1'b1};
    assign unused_s = ^{PENABLE, EXRESPM, PADDR[1:0], PSTRB};
`endif

    assign addr_d = {PADDR[ADDR_WIDTH-1:2], dec_s.lsbs};

    // Transfer sequencer; pslverr_q doubles as the error flag reported in RESP.
    always_ff @(posedge HCLK or negedge nPOR) begin
        if (!nPOR) begin
            state_q   <= ST_IDLE;
            hsel_q    <= 1'b0;
            htrans_q  <= HTRANS_IDLE;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            hsize_q   <= HSIZE_WORD;
            hwdata_q  <= 32'h0000_0000;
            prdata_q  <= 32'h0000_0000;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    if (PSEL) begin
                        if (dec_s.valid) begin
                            state_q  <= ST_ADDR;
                            hsel_q   <= 1'b1;
                            htrans_q <= HTRANS_NONSEQ;
                            haddr_q  <= addr_d;
                            hwrite_q <= PWRITE;
                            hsize_q  <= dec_s.size;
                            if (PWRITE) begin
                                hwdata_q <= PWDATA;
                            end
                        end else begin
                            // Unsupported strobe pattern: answer the APB side without touching AHB.
                            state_q   <= ST_RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (HREADYM) begin
                        state_q  <= ST_DATA;
                        hsel_q   <= 1'b0;
                        htrans_q <= HTRANS_IDLE;
                    end
                end
                ST_DATA: begin
                    if (HREADYM && !HRESPM) begin
                        if (!hwrite_q) begin
                            prdata_q <= HRDATAM;
                        end
                        state_q   <= ST_RESP;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b0;
                    end else if (HREADYM && HRESPM) begin
                        // Single-cycle ERROR is a slave protocol violation; still report it.
                        state_q   <= ST_RESP;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b1;
                    end else if (HRESPM) begin
                        state_q <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    if (HREADYM) begin
                        state_q   <= ST_RESP;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q   <= ST_IDLE;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    hsel_q    <= 1'b0;
                    htrans_q  <= HTRANS_IDLE;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                end
            endcase
        end
    end

    assign HSELM      = hsel_q;
    assign HTRANSM    = htrans_q;
    assign HADDRM     = haddr_q;
    assign HWRITEM    = hwrite_q;
    assign HSIZEM     = hsize_q;
    assign HWDATAM    = hwdata_q;
    assign PRDATA     = prdata_q;
    assign PREADY     = pready_q;
    assign PSLVERR    = pslverr_q;

    assign HMASTERM   = 4'h0;
    assign HMASTLOCKM = 1'b0;
    assign HBURSTM    = HBURST_SINGLE;
    assign HPROTM     = HPROT_VALUE;
    assign MEMATTRM   = 2'b00;
    assign EXREQM     = 1'b0;

endmodule

// File: tb/tb_fpga_apb_ahb_bridge.sv
// Randomized bench for fpga_apb_ahb_bridge with a transaction-level timeline model.
module tb_fpga_apb_ahb_bridge;

`ifdef FPGA_APB_AHB_STRB_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        nPOR;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        HSELM, HWRITEM, HMASTLOCKM, EXREQM;
    logic [31:0] HADDRM;
    logic [1:0]  HTRANSM;
    logic [2:0]  HSIZEM, HBURSTM;
    logic [3:0]  HMASTERM, HPROTM;
    logic [1:0]  MEMATTRM;
    logic [31:0] HWDATAM;
    logic        HREADYM, HRESPM, EXRESPM;
    logic [31:0] HRDATAM;

    fpga_apb_ahb_bridge dut (
        .HCLK(HCLK), .nPOR(nPOR),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .HSELM(HSELM), .HWRITEM(HWRITEM), .HMASTLOCKM(HMASTLOCKM), .EXREQM(EXREQM),
        .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HSIZEM(HSIZEM), .HBURSTM(HBURSTM),
        .HMASTERM(HMASTERM), .HPROTM(HPROTM), .MEMATTRM(MEMATTRM), .HWDATAM(HWDATAM),
        .HREADYM(HREADYM), .HRESPM(HRESPM), .EXRESPM(EXRESPM), .HRDATAM(HRDATAM)
    );

    always #5 HCLK = ~HCLK;

    int n_vec = 0;
    int n_err = 0;
    int nonseq_cnt = 0;

    // Per-cycle expectations published by the driver, checked at the falling edge.
    bit          exp_valid = 1'b0;
    bit          exp_hsel, exp_achk, exp_wchk, exp_pready, exp_pslverr, exp_hwrite;
    logic [1:0]  exp_htrans;
    logic [2:0]  exp_hsize;
    logic [31:0] exp_haddr, exp_hwdata, exp_prdata;
    logic [31:0] last_prdata = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Size/lsbs/legality of a transfer, from the strobe rules.
    function automatic void model_decode(input bit wr, input logic [3:0] strb,
                                         output logic [2:0] sz, output logic [1:0] lsb,
                                         output bit ok);
        int ones;
        int low;
        sz = 3'b010; lsb = 2'b00; ok = 1'b1;
        ones = $countones(strb);
        low = 0;
        for (int i = 3; i >= 0; i--) if (strb[i]) low = i;
        if (STRB_EN && wr && strb != 4'hF) begin
            if (ones == 1) begin
                sz = 3'b000; lsb = 2'(low);
            end else if (ones == 2 && (low == 0 || low == 2) && strb[low+1]) begin
                sz = 3'b001; lsb = 2'(low);
            end else begin
                ok = 1'b0;
            end
        end
    endfunction

    // emode: 0 OKAY, 1 two-cycle ERROR, 2 single-cycle ERROR (protocol violation)
    task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int a, input int d, input int emode,
                           input logic [31:0] rdata, output int resp_k);
        logic [2:0] sz;
        logic [1:0] lsb;
        bit ok;
        int ds;
        int j;
        model_decode(wr, strb, sz, lsb, ok);
        ds = 2 + a;
        resp_k = ok ? (ds + d + 1 + ((emode == 1) ? 1 : 0)) : 1;
        for (int k = 0; k <= resp_k; k++) begin
            @(posedge HCLK); #1;
            PSEL = 1'b1; PENABLE = (k > 0); PWRITE = wr;
            PADDR = addr; PWDATA = wdata; PSTRB = strb;
            HREADYM = 1'b1; HRESPM = 1'b0; HRDATAM = $urandom;
            if (ok && k >= 1 && k < ds) HREADYM = (k == ds - 1);
            if (ok && k >= ds && k < resp_k) begin
                j = k - ds;
                if (j < d) begin
                    HREADYM = 1'b0;
                end else if (emode == 0) begin
                    if (!wr) HRDATAM = rdata;
                end else if (emode == 2) begin
                    HRESPM = 1'b1;
                end else begin
                    HREADYM = (j == d + 1); HRESPM = 1'b1;
                end
            end
            exp_hsel    = ok && k >= 1 && k < ds;
            exp_htrans  = exp_hsel ? 2'b10 : 2'b00;
            exp_achk    = exp_hsel;
            exp_haddr   = {addr[31:2], lsb};
            exp_hwrite  = wr;
            exp_hsize   = sz;
            exp_wchk    = ok && wr && k >= 1 && k < resp_k;
            exp_hwdata  = wdata;
            exp_pready  = (k == resp_k);
            exp_pslverr = !ok || emode != 0;
            if (k == resp_k && ok && !wr && emode == 0) last_prdata = rdata;
            exp_prdata  = last_prdata;
            exp_valid   = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge HCLK); #1;
            PSEL = 1'b0; PENABLE = 1'b0; PADDR = $urandom;
            HREADYM = 1'b1; HRESPM = 1'b0; HRDATAM = $urandom;
            exp_hsel = 1'b0; exp_htrans = 2'b00; exp_achk = 1'b0; exp_wchk = 1'b0;
            exp_pready = 1'b0; exp_prdata = last_prdata; exp_valid = 1'b1;
        end
    endtask

    always @(posedge HCLK) begin
        if (nPOR && HTRANSM == 2'b10 && HREADYM) nonseq_cnt <= nonseq_cnt + 1;
    end

    // Single compare point for every modelled cycle.
    always @(negedge HCLK) begin
        if (exp_valid) begin
            chk("hsel", HSELM, exp_hsel);
            chk("htrans", HTRANSM, exp_htrans);
            if (exp_achk) begin
                chk("haddr", HADDRM, exp_haddr);
                chk("hwrite", HWRITEM, exp_hwrite);
                chk("hsize", HSIZEM, exp_hsize);
            end
            if (exp_wchk) chk("hwdata", HWDATAM, exp_hwdata);
            chk("pready", PREADY, exp_pready);
            if (exp_pready) chk("pslverr", PSLVERR, exp_pslverr);
            chk("prdata", PRDATA, exp_prdata);
            chk("consts", {HMASTERM, HMASTLOCKM, HBURSTM, HPROTM, MEMATTRM, EXREQM},
                {4'h0, 1'b0, 3'b000, 4'hF, 2'b00, 1'b0});
        end
    end

    initial begin
        int rk;
        int n0;
        bit wr;
        int em;
        logic [3:0] strb;
        nPOR = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'h0; PWDATA = 32'h0; PSTRB = 4'h0;
        HREADYM = 1'b1; HRESPM = 1'b0; EXRESPM = 1'b0; HRDATAM = 32'h0;
        #12;
        chk("rst_hsel", HSELM, 1'b0);
        chk("rst_htrans", HTRANSM, 2'b00);
        chk("rst_haddr", HADDRM, 32'h0);
        chk("rst_hwrite", HWRITEM, 1'b0);
        chk("rst_hsize", HSIZEM, 3'b010);
        chk("rst_hwdata", HWDATAM, 32'h0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pready", PREADY, 1'b0);
        chk("rst_pslverr", PSLVERR, 1'b0);
        @(posedge HCLK); #1 nPOR = 1'b1;

        n0 = nonseq_cnt;
        do_xfer(1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 32'h0, rk);
        chk("wr0_latency", rk, 3);
        chk("wr0_nonseq", nonseq_cnt - n0, 1);

        do_xfer(1'b0, 32'h2000_0020, 32'h0, 4'h0, 0, 2, 0, 32'h1234_5678, rk);
        chk("rd2w_latency", rk, 5);
        chk("rd2w_prdata", PRDATA, 32'h1234_5678);
        idle(1);

        n0 = nonseq_cnt;
        do_xfer(1'b1, 32'h2000_0030, 32'h0BAD_F00D, 4'hF, 0, 0, 1, 32'h0, rk);
        chk("err_latency", rk, 4);
        chk("err_pslverr", PSLVERR, 1'b1);
        chk("err_nonseq", nonseq_cnt - n0, 1);

        do_xfer(1'b0, 32'h2000_0040, 32'h0, 4'h0, 1, 0, 2, 32'hFFFF_0000, rk);
        chk("viol_prdata_kept", PRDATA, 32'h1234_5678);

        n0 = nonseq_cnt;
        do_xfer(1'b0, 32'h2000_0100, 32'h0, 4'h0, 0, 0, 0, 32'h1111_2222, rk);
        do_xfer(1'b0, 32'h2000_0104, 32'h0, 4'h0, 0, 0, 0, 32'h3333_4444, rk);
        chk("b2b_nonseq", nonseq_cnt - n0, 2);
        chk("b2b_prdata", PRDATA, 32'h3333_4444);

`ifdef FPGA_APB_AHB_STRB_EN
        begin
            logic [2:0] sz;
            logic [1:0] lsb;
            bit ok;
            model_decode(1'b1, 4'b1100, sz, lsb, ok);
            chk("model_half_size", sz, 3'b001);
            chk("model_half_lsb", lsb, 2'b10);
        end
        do_xfer(1'b1, 32'h4000_0000, 32'hCAFE_0000, 4'b1100, 0, 0, 0, 32'h0, rk);
        n0 = nonseq_cnt;
        do_xfer(1'b1, 32'h4000_0008, 32'h5555_AAAA, 4'b0101, 0, 0, 0, 32'h0, rk);
        chk("badstrb_latency", rk, 1);
        chk("badstrb_nonseq", nonseq_cnt - n0, 0);
`endif

        // Reset while the data phase is stalled.
        @(posedge HCLK); #1;
        exp_valid = 1'b0;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h3000_0044;
        PWDATA = 32'hA5A5_5A5A; PSTRB = 4'hF; HREADYM = 1'b1; HRESPM = 1'b0;
        @(posedge HCLK); #1 PENABLE = 1'b1;
        @(posedge HCLK); #1 HREADYM = 1'b0;
        chk("prerst_hwdata", HWDATAM, 32'hA5A5_5A5A);
        #2 nPOR = 1'b0;
        #1;
        chk("arst_htrans", HTRANSM, 2'b00);
        chk("arst_hsel", HSELM, 1'b0);
        chk("arst_pready", PREADY, 1'b0);
        chk("arst_haddr", HADDRM, 32'h0);
        chk("arst_hwdata", HWDATAM, 32'h0);
        chk("arst_prdata", PRDATA, 32'h0);
        @(posedge HCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; HREADYM = 1'b1;
        @(posedge HCLK); #1 nPOR = 1'b1;
        last_prdata = 32'h0;
        do_xfer(1'b1, 32'h2000_0200, 32'h0102_0304, 4'hF, 0, 0, 0, 32'h0, rk);
        chk("postrst_latency", rk, 3);

        for (int t = 0; t < 200; t++) begin
            wr = 1'($urandom_range(0, 1));
            strb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) strb = 4'hF;
            em = $urandom_range(0, 5);
            em = (em >= 4) ? em - 3 : 0;
            do_xfer(wr, $urandom, $urandom, strb, $urandom_range(0, 2),
                    $urandom_range(0, 3), em, $urandom, rk);
            idle($urandom_range(0, 2));
        end

        @(posedge HCLK); #1 exp_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
